ysyx_24090003_wbu: RTL and testbench
====================================

# ysyx_24090003_wbu

Write-back/commit unit sitting directly after the execute stage. It consumes the registered EX results: register write, memory store, next-PC and sequential-PC, each with its own enable. It drives the register-file write port, a valid/ready data-memory store port and the architectural PC. Its 1-cycle-per-instruction flow stalls the execute stage only while a store is outstanding.

## Interface
- RESET_PC, 32'h8000_0000, PC value after reset
- STORE_TIMEOUT, 255, cycles `mem_wvalid` may wait for `mem_wready` before the error flag sets (8-bit counter)
- cpu_clk  in  1  single clock, all state on rising edge
- cpu_rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX result present this cycle
- ex_ready  out  1  WBU accepts; combinational, `= (state == IDLE)`
- ex_rd  in  5  destination register
- ex_reg_wdata  in  32  register write data
- ex_reg_wen  in  1  register write requested
- ex_addr  in  32  store address
- ex_addr_wdata  in  32  store data
- ex_addr_wen  in  1  store requested
- ex_npc  in  32  redirect target
- ex_npc_wen  in  1  redirect requested
- ex_spc  in  32  PC of the instruction
- ex_spc_wen  in  1  sequential PC supplied
- rf_wen / rf_waddr / rf_wdata  out  1/5/32  register-file write port, registered
- mem_wvalid / mem_waddr / mem_wdata  out  1/32/32  store request, registered
- mem_wready  in  1  memory accepts store
- pc  out  32  architectural PC
- commit  out  1  one-cycle retire pulse
- retire_cnt  out  32  retired-instruction count
- store_timeout_err  out  1  sticky store-timeout flag

## Operation
- FSM states: IDLE, MEM_WAIT.
- Accept = `ex_valid & ex_ready`. All `ex_*` fields are latched on accept.
- IDLE, accept, `ex_addr_wen=0`:
  - next cycle `commit=1`.
  - `rf_wen = ex_reg_wen & (ex_rd != 0)`; writes to x0 are suppressed, though commit still pulses.
  - Stay in IDLE.
- IDLE, accept, `ex_addr_wen=1`:
  - Go to MEM_WAIT.
  - Next cycle `mem_wvalid=1`, with `mem_waddr`/`mem_wdata` held stable until the handshake.
  - Timeout counter cleared.
- MEM_WAIT:
  - When `mem_wvalid & mem_wready`: next cycle `mem_wvalid=0`, `commit=1`, `rf_wen` from latched fields, state IDLE.
  - Otherwise the counter increments, saturating at 255. `store_timeout_err` sets when counter == STORE_TIMEOUT and stays set until reset.
  - No abort: the FSM keeps waiting after timeout.
- PC update on the commit cycle:
  - `pc = npc` if npc_wen.
  - else `spc + 4` if spc_wen.
  - else `pc + 4`.
  - Addition is 32-bit and wraps modulo 2^32.
- `retire_cnt` increments by 1 on every commit and wraps at 2^32 to 0.
- The store address is passed unmodified; misalignment is not checked.
- `ex_valid=0` in IDLE: no outputs asserted, no state change.

## Timing
- Reset values:
  - pc = RESET_PC
  - state = IDLE, so `ex_ready=1`
  - retire_cnt = 0
  - store_timeout_err = 0
  - commit, rf_wen, mem_wvalid = 0
  - rf_waddr, rf_wdata, mem_waddr, mem_wdata = 0
- Latency:
  - Non-store: accept in cycle N gives commit, rf_wen and the new pc visible in N+1. Throughput is 1 per cycle.
  - Store: accept in N gives `mem_wvalid` in N+1. A handshake in M gives commit in M+1. `ex_ready` is 0 from N+1 through M and 1 again in M+1.
  - A store with `mem_wready` already high in N+1 commits in N+2. Minimum store occupancy is 2 cycles.
- Store with `ex_reg_wen=1`: register write and PC update both occur in the single commit cycle.
- `npc_wen` and `spc_wen` both set: npc wins.
- Reset mid-store has priority over everything:
  - The store is dropped and `mem_wvalid` is 0 the next cycle.
  - No commit; the instruction is not retired.
- Reset in the same cycle as an accept: the accept is ignored.

## Structure
- Shared package `ysyx_24090003_pkg` holds:
  - the state encoding, IDLE=1'b0 and MEM_WAIT=1'b1
  - RESET_PC default
  - the x0 index constant 5'd0
  - the PC increment constant 32'd4
- Single module. The FSM, timeout counter and retire counter are inline, because each is under 20 lines and no sub-module is warranted.

## Test plan
- Reset, then ADDI x5 with data 0x0000_002A, `ex_spc`=0x8000_0000, `spc_wen=1` → next cycle: commit=1, rf_wen=1, rf_waddr=5, rf_wdata=0x2A, pc=0x8000_0004, retire_cnt=1.
- Four back-to-back non-store results, one per cycle → ex_ready never drops, commit high for 4 consecutive cycles, retire_cnt=4.
- `ex_rd=0`, `reg_wen=1` → commit=1, rf_wen=0.
- Store to 0x8000_1000 with data 0xDEAD_BEEF; `mem_wready` held low 3 cycles then high → mem_wvalid high 4 cycles with stable addr/data, ex_ready=0 throughout, commit exactly one cycle after the handshake.
- STORE_TIMEOUT=4, `mem_wready` low for 10 cycles → store_timeout_err rises after the 4th wait cycle. The flag stays 1 after the eventual handshake and commit, and clears only on cpu_rst.
- Additional cases:
  - `npc_wen` and `spc_wen` both set (npc=0x8000_0100, spc=0x8000_0000) → pc=0x8000_0100.
  - cpu_rst asserted during MEM_WAIT → next cycle mem_wvalid=0, pc=RESET_PC, retire_cnt=0, no commit.

Source files
------------

// File: rtl/ysyx_24090003_pkg.sv
// Shared types and constants for the ysyx_24090003 write-back unit.
// State encoding, reset PC and the EX result bundle live here.
package ysyx_24090003_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wbu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [4:0]  X0_IDX       = 5'd0;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] reg_wdata;
    logic        reg_wen;
    logic [31:0] npc;
    logic        npc_wen;
    logic [31:0] spc;
    logic        spc_wen;
  } ex_res_t;

endpackage

// File: rtl/ysyx_24090003_wbu.sv
// Write-back/commit unit: retires EX results, issues stores over a
// valid/ready port and owns the architectural PC and retire counter.
module ysyx_24090003_wbu
  import ysyx_24090003_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
  parameter int unsigned STORE_TIMEOUT = 255
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_reg_wdata,
  input  logic        ex_reg_wen,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_addr_wdata,
  input  logic        ex_addr_wen,
  input  logic [31:0] ex_npc,
  input  logic        ex_npc_wen,
  input  logic [31:0] ex_spc,
  input  logic        ex_spc_wen,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        mem_wvalid,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wready,
  output logic [31:0] pc,
  output logic        commit,
  output logic [31:0] retire_cnt,
  output logic        store_timeout_err
);

  localparam logic [7:0] TO_VAL = 8'(STORE_TIMEOUT);

  wbu_state_e  state;
  wbu_state_e  state_nxt;
  ex_res_t     lat;
  ex_res_t     ex_in;
  ex_res_t     src;
  logic        accept;
  logic        hs;
  logic        do_commit;
  logic        st_accept;
  logic [31:0] pc_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;

  assign ex_ready  = (state == IDLE);
  assign accept    = ex_valid & ex_ready;
  assign hs        = mem_wvalid & mem_wready;
  assign st_accept = accept & ex_addr_wen;

  always_comb begin
    ex_in = '{
      rd:        ex_rd,
      reg_wdata: ex_reg_wdata,
      reg_wen:   ex_reg_wen,
      npc:       ex_npc,
      npc_wen:   ex_npc_wen,
      spc:       ex_spc,
      spc_wen:   ex_spc_wen
    };
  end

  // Non-stores retire straight from the EX bundle; stores from the latch.
  always_comb begin
    state_nxt = state;
    do_commit = 1'b0;
    src       = ex_in;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (ex_addr_wen) state_nxt = MEM_WAIT;
          else do_commit = 1'b1;
        end
      end
      MEM_WAIT: begin
        src = lat;
        if (hs) begin
          state_nxt = IDLE;
          do_commit = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    if (src.npc_wen) pc_nxt = src.npc;
    else if (src.spc_wen) pc_nxt = src.spc + PC_INC;
    else pc_nxt = pc + PC_INC;
  end

  assign wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state             <= IDLE;
      lat               <= '0;
      pc                <= RESET_PC;
      retire_cnt        <= '0;
      commit            <= 1'b0;
      rf_wen            <= 1'b0;
      rf_waddr          <= '0;
      rf_wdata          <= '0;
      mem_wvalid        <= 1'b0;
      mem_waddr         <= '0;
      mem_wdata         <= '0;
      wait_cnt          <= '0;
      store_timeout_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      commit <= do_commit;
      rf_wen <= do_commit & src.reg_wen & (src.rd != X0_IDX);
      if (do_commit) begin
        rf_waddr   <= src.rd;
        rf_wdata   <= src.reg_wdata;
        pc         <= pc_nxt;
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (st_accept) begin
        lat        <= ex_in;
        mem_wvalid <= 1'b1;
        mem_waddr  <= ex_addr;
        mem_wdata  <= ex_addr_wdata;
        wait_cnt   <= '0;
      end else if (hs) begin
        mem_wvalid <= 1'b0;
      end
      // Waiting never aborts; the flag only records a slow memory.
      if (state == MEM_WAIT && !hs) begin
        wait_cnt <= wait_nxt;
        if (wait_nxt == TO_VAL) store_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Self-checking bench for ysyx_24090003_wbu: directed cases plus
// randomized traffic against a transaction-level model.
module tb_ysyx_24090003_wbu;

  localparam int          TO  = 4;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd = '0;
  logic [31:0] ex_reg_wdata = '0;
  logic        ex_reg_wen = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_addr_wdata = '0;
  logic        ex_addr_wen = 1'b0;
  logic [31:0] ex_npc = '0;
  logic        ex_npc_wen = 1'b0;
  logic [31:0] ex_spc = '0;
  logic        ex_spc_wen = 1'b0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        mem_wvalid;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wready = 1'b0;
  logic [31:0] pc;
  logic        commit;
  logic [31:0] retire_cnt;
  logic        store_timeout_err;

  always #5 cpu_clk = ~cpu_clk;

  ysyx_24090003_wbu #(
    .RESET_PC(RPC),
    .STORE_TIMEOUT(TO)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .ex_valid(ex_valid),
    .ex_ready(ex_ready),
    .ex_rd(ex_rd),
    .ex_reg_wdata(ex_reg_wdata),
    .ex_reg_wen(ex_reg_wen),
    .ex_addr(ex_addr),
    .ex_addr_wdata(ex_addr_wdata),
    .ex_addr_wen(ex_addr_wen),
    .ex_npc(ex_npc),
    .ex_npc_wen(ex_npc_wen),
    .ex_spc(ex_spc),
    .ex_spc_wen(ex_spc_wen),
    .rf_wen(rf_wen),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .mem_wvalid(mem_wvalid),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .mem_wready(mem_wready),
    .pc(pc),
    .commit(commit),
    .retire_cnt(retire_cnt),
    .store_timeout_err(store_timeout_err)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
    logic        rw;
    logic [31:0] npc;
    logic        nw;
    logic [31:0] spc;
    logic        sw;
  } ins_t;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_pc = RPC;
  logic [31:0] m_ret = '0;
  logic        m_err = 1'b0;
  logic        m_busy = 1'b0;
  int          m_waits = 0;
  ins_t        m_pend;
  logic        m_commit = 1'b0;
  logic        m_rfwen = 1'b0;
  logic [4:0]  m_rfa = '0;
  logic [31:0] m_rfd = '0;
  logic        m_mwv = 1'b0;
  logic [31:0] m_ma = '0;
  logic [31:0] m_md = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic retire(ins_t t);
    m_commit = 1'b1;
    m_rfwen  = t.rw && (t.rd != 5'd0);
    m_rfa    = t.rd;
    m_rfd    = t.wd;
    if (t.nw) m_pc = t.npc;
    else if (t.sw) m_pc = t.spc + 32'd4;
    else m_pc = m_pc + 32'd4;
    m_ret = m_ret + 32'd1;
  endtask

  task automatic model();
    ins_t c;
    c = '{rd: ex_rd, wd: ex_reg_wdata, rw: ex_reg_wen, npc: ex_npc,
          nw: ex_npc_wen, spc: ex_spc, sw: ex_spc_wen};
    if (cpu_rst) begin
      m_pc = RPC; m_ret = '0; m_err = 1'b0; m_busy = 1'b0;
      m_commit = 1'b0; m_rfwen = 1'b0; m_mwv = 1'b0; m_waits = 0;
    end else begin
      m_commit = 1'b0;
      m_rfwen  = 1'b0;
      if (m_busy) begin
        if (mem_wready) begin
          m_busy = 1'b0;
          m_mwv  = 1'b0;
          retire(m_pend);
        end else begin
          if (m_waits < 255) m_waits++;
          if (m_waits == TO) m_err = 1'b1;
        end
      end else if (ex_valid) begin
        if (ex_addr_wen) begin
          m_busy = 1'b1; m_mwv = 1'b1; m_waits = 0;
          m_ma = ex_addr; m_md = ex_addr_wdata; m_pend = c;
        end else begin
          retire(c);
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("ex_ready", 32'(ex_ready), 32'(!m_busy));
    chk("commit", 32'(commit), 32'(m_commit));
    chk("rf_wen", 32'(rf_wen), 32'(m_rfwen));
    chk("mem_wvalid", 32'(mem_wvalid), 32'(m_mwv));
    chk("pc", pc, m_pc);
    chk("retire_cnt", retire_cnt, m_ret);
    chk("timeout_err", 32'(store_timeout_err), 32'(m_err));
    if (m_rfwen) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(m_rfa));
      chk("rf_wdata", rf_wdata, m_rfd);
    end
    if (m_mwv) begin
      chk("mem_waddr", mem_waddr, m_ma);
      chk("mem_wdata", mem_wdata, m_md);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    model();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_addr_wen = 1'b0; ex_reg_wen = 1'b0;
    ex_npc_wen = 1'b0; ex_spc_wen = 1'b0;
  endtask

  task automatic do_reset();
    cpu_rst = 1'b1; idle_in(); mem_wready = 1'b0;
    step();
    cpu_rst = 1'b0;
  endtask

  task automatic alu(logic [4:0] rd, logic [31:0] d, logic [31:0] spc);
    ex_valid = 1'b1; ex_addr_wen = 1'b0; ex_rd = rd; ex_reg_wdata = d;
    ex_reg_wen = 1'b1; ex_spc = spc; ex_spc_wen = 1'b1; ex_npc_wen = 1'b0;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    ex_valid = 1'b1; ex_addr_wen = 1'b1; ex_addr = a; ex_addr_wdata = d;
    ex_reg_wen = 1'b0; ex_npc_wen = 1'b0; ex_spc_wen = 1'b0;
  endtask

  task automatic rnd_in();
    ex_valid      = ($urandom_range(0, 3) != 0);
    ex_rd         = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    ex_reg_wdata  = $urandom;
    ex_reg_wen    = 1'($urandom);
    ex_addr       = $urandom;
    ex_addr_wdata = $urandom;
    ex_addr_wen   = ($urandom_range(0, 3) == 0);
    ex_npc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
    ex_npc_wen    = ($urandom_range(0, 3) == 0);
    ex_spc        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
    ex_spc_wen    = 1'($urandom);
    mem_wready    = ($urandom_range(0, 2) == 0);
    cpu_rst       = ($urandom_range(0, 79) == 0);
  endtask

  initial begin
    // reset values
    do_reset();
    chk("rst pc", pc, 32'h8000_0000);
    chk("rst ready", 32'(ex_ready), 32'd1);
    chk("rst retire", retire_cnt, 32'd0);
    chk("rst err", 32'(store_timeout_err), 32'd0);
    chk("rst outs", {29'd0, commit, rf_wen, mem_wvalid}, 32'd0);
    chk("rst rf", {27'd0, rf_waddr} | rf_wdata, 32'd0);
    chk("rst mem", mem_waddr | mem_wdata, 32'd0);

    // single ADDI x5
    alu(5'd5, 32'h0000_002A, 32'h8000_0000);
    step();
    idle_in();
    chk("addi commit", 32'(commit), 32'd1);
    chk("addi rf_wen", 32'(rf_wen), 32'd1);
    chk("addi rd", 32'(rf_waddr), 32'd5);
    chk("addi data", rf_wdata, 32'h2A);
    chk("addi pc", pc, 32'h8000_0004);
    chk("addi retire", retire_cnt, 32'd1);
    step();
    chk("addi no commit", 32'(commit), 32'd0);

    // four back-to-back
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alu(5'(i + 1), 32'(i * 3), 32'h8000_0000 + 32'(i * 4));
      chk("b2b ready", 32'(ex_ready), 32'd1);
      step();
      chk("b2b commit", 32'(commit), 32'd1);
    end
    idle_in();
    chk("b2b retire", retire_cnt, 32'd4);
    chk("b2b pc", pc, 32'h8000_0010);

    // write to x0
    alu(5'd0, 32'h1234_5678, 32'h8000_0010);
    step();
    idle_in();
    chk("x0 commit", 32'(commit), 32'd1);
    chk("x0 rf_wen", 32'(rf_wen), 32'd0);

    // store with 3 wait cycles
    do_reset();
    store(32'h8000_1000, 32'hDEAD_BEEF);
    step();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      mem_wready = (k == 3);
      chk("st wvalid", 32'(mem_wvalid), 32'd1);
      chk("st addr", mem_waddr, 32'h8000_1000);
      chk("st data", mem_wdata, 32'hDEAD_BEEF);
      chk("st ready", 32'(ex_ready), 32'd0);
      chk("st early commit", 32'(commit), 32'd0);
      step();
    end
    mem_wready = 1'b0;
    chk("st commit", 32'(commit), 32'd1);
    chk("st wvalid done", 32'(mem_wvalid), 32'd0);
    chk("st ready back", 32'(ex_ready), 32'd1);
    chk("st pc", pc, 32'h8000_0004);
    step();

    // timeout flag, sticky until reset
    do_reset();
    store(32'h8000_2000, 32'h0BAD_F00D);
    step();
    idle_in();
    for (int k = 0; k < 10; k++) begin
      chk("to flag", 32'(store_timeout_err), (k >= TO) ? 32'd1 : 32'd0);
      step();
    end
    mem_wready = 1'b1;
    step();
    mem_wready = 1'b0;
    step();
    chk("to commit seen", retire_cnt, 32'd1);
    chk("to sticky", 32'(store_timeout_err), 32'd1);
    do_reset();
    chk("to cleared", 32'(store_timeout_err), 32'd0);

    // npc beats spc
    alu(5'd3, 32'd7, 32'h8000_0000);
    ex_npc = 32'h8000_0100; ex_npc_wen = 1'b1;
    step();
    idle_in();
    chk("npc wins", pc, 32'h8000_0100);

    // reset during MEM_WAIT
    store(32'h8000_3000, 32'h1111_2222);
    step();
    idle_in();
    mem_wready = 1'b1;
    cpu_rst = 1'b1;
    step();
    cpu_rst = 1'b0;
    mem_wready = 1'b0;
    chk("mrst wvalid", 32'(mem_wvalid), 32'd0);
    chk("mrst commit", 32'(commit), 32'd0);
    chk("mrst pc", pc, 32'h8000_0000);
    chk("mrst retire", retire_cnt, 32'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rnd_in();
      step();
    end
    cpu_rst = 1'b0;
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
